rr_arb_out_fifo: RTL and testbench
==================================

// Module: rr_arb_out_fifo
// PURPOSE
//  Synchronous first-word-fall-through (FWFT) FIFO on the output of the two-input round-robin arbiter.
//  - Consumes the arbiter's next_valid/next_ready/next_data stream.
//  - Decouples arbiter grant timing from downstream back-pressure.
//  - Gives downstream a registered valid/data interface, plus occupancy and almost-full status.
// PARAMETERS
//  DATA_WIDTH  16  payload width; must equal the arbiter DATA_WIDTH
//  DEPTH       4   number of entries; power of two, >= 2
//  AFULL_THR   3   almost_full_o is 1 when count_o >= AFULL_THR; range 1..DEPTH
// PORTS
//  aclk          in   1                     clock; all logic on the rising edge
//  areset        in   1                     reset; synchronous, active-high
//  prev_valid_i  in   1                     upstream (arbiter) data valid
//  prev_ready_o  out  1                     FIFO can accept a word this cycle
//  prev_data_i   in   DATA_WIDTH            upstream payload
//  next_valid_o  out  1                     head entry valid (FWFT)
//  next_ready_i  in   1                     downstream accepts the head entry
//  next_data_o   out  DATA_WIDTH            head entry payload
//  count_o       out  $clog2(DEPTH+1)       current occupancy, 0..DEPTH
//  almost_full_o out  1                     count_o >= AFULL_THR
// BEHAVIOUR
//  - Reset (areset=1 at a rising edge):
//    - wr_ptr=0, rd_ptr=0, count=0.
//    - next_valid_o=0, prev_ready_o=1 on the following cycle.
//    - count_o=0, almost_full_o=0.
//    - Storage array is not reset; next_data_o is don't-care while next_valid_o=0.
//    - Reset mid-operation discards all entries. A push or pop in the reset cycle is ignored.
//  - Handshakes:
//    - push = prev_valid_i & prev_ready_o; pop = next_valid_o & next_ready_i.
//    - prev_ready_o = (count != DEPTH). It depends only on state, never combinationally on next_ready_i.
//    - next_valid_o = (count != 0). next_data_o = mem[rd_ptr], combinational read of the registered array.
//    - Once next_valid_o=1, next_data_o stays stable until the pop occurs.
//  - Latency:
//    - A word pushed in cycle N appears on next_data_o with next_valid_o=1 in cycle N+1, if the FIFO was empty.
//    - No same-cycle flow-through: an empty FIFO never presents data in the push cycle.
//  - Pointers:
//    - $clog2(DEPTH)-bit wr_ptr and rd_ptr; each increments by 1 on push/pop and wraps DEPTH-1 -> 0 naturally.
//    - count is tracked separately, width $clog2(DEPTH+1):
//      push&~pop: +1; pop&~push: -1; both or neither: unchanged.
//  - Boundary conditions:
//    - Full (count=DEPTH): prev_ready_o=0, so a push cannot occur.
//      A pop in the full cycle restores prev_ready_o=1 the next cycle (one-cycle bubble by design).
//    - Empty (count=0): next_valid_o=0, so a pop cannot occur. A simultaneous push is accepted alone.
//    - Simultaneous push and pop with 0<count<DEPTH: both pointers advance, count unchanged, order preserved.
//    - prev_valid_i=0: prev_data_i is ignored (it may be X from the arbiter).
//    - next_ready_i=1 while empty: no effect.
//  - Ordering: strict FIFO; data is never dropped, duplicated or reordered.
//  - State machine: implicit, via count. EMPTY (0) -> PARTIAL (1..DEPTH-1) -> FULL (DEPTH), transitions only via the count rule above.
//  - almost_full_o is registered-equivalent: a function of the count register only, so it has no combinational input path.
// TESTING (DATA_WIDTH=16, DEPTH=4, AFULL_THR=3)
//  1. Reset, then idle
//     -> next_valid_o=0, prev_ready_o=1, count_o=0, almost_full_o=0.
//  2. Push 0xA001 in cycle 1, next_ready_i=0
//     -> cycle 2: next_valid_o=1, next_data_o=0xA001, count_o=1.
//  3. Push 0x0001..0x0004 back-to-back, next_ready_i=0
//     -> count_o=4, prev_ready_o=0, almost_full_o=1 from count 3.
//     -> A further push of 0x0005 is not accepted.
//     -> Then pop 4 words -> 0x0001,0x0002,0x0003,0x0004 in order, count_o=0.
//  4. Steady stream with prev_valid_i=1 and next_ready_i=1, 12 words 0x0100..0x010B
//     -> every word is output once, in order.
//     -> After a 1-cycle fill latency, count_o holds at 1.
//     -> Pointers wrap 3 times.
//  5. Random prev_valid_i/next_ready_i (50%) over 1000 cycles
//     -> scoreboard matches input order, count_o always equals pushes-pops.
//     -> Never a push while full or a pop while empty.
//  6. Hold 3 entries, assert areset for 1 cycle together with prev_valid_i=1 and next_ready_i=1
//     -> next cycle: count_o=0, next_valid_o=0.
//     -> The first word pushed afterwards is the first word output.

Source files
------------

// File: rtl/rr_arb_out_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_out_fifo_if
//  Description : Stream bundle between the round-robin arbiter output, the
//                output FIFO and its downstream consumer, plus FIFO status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface rr_arb_out_fifo_if #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4
);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   // upstream (arbiter -> FIFO)
   logic                  prev_valid_i;
   logic                  prev_ready_o;
   logic [DATA_WIDTH-1:0] prev_data_i;
   // downstream (FIFO -> consumer)
   logic                  next_valid_o;
   logic                  next_ready_i;
   logic [DATA_WIDTH-1:0] next_data_o;
   // status
   logic [c_CNT_W-1:0]    count_o;
   logic                  almost_full_o;

   // FIFO side of the bundle
   modport slave (
      input  prev_valid_i,
      output prev_ready_o,
      input  prev_data_i,
      output next_valid_o,
      input  next_ready_i,
      output next_data_o,
      output count_o,
      output almost_full_o
   );

   // Environment side: drives upstream data and downstream ready
   modport master (
      output prev_valid_i,
      input  prev_ready_o,
      output prev_data_i,
      input  next_valid_o,
      output next_ready_i,
      input  next_data_o,
      input  count_o,
      input  almost_full_o
   );
endinterface
`default_nettype wire

// File: rtl/rr_arb_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb_out_fifo
//  Description : First-word-fall-through FIFO on the output of the two-input
//                round-robin arbiter. Decouples grant timing from downstream
//                back-pressure; exposes occupancy and almost-full status.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb_out_fifo #(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 4,
   parameter int AFULL_THR  = 3
) (
   input  wire                  aclk,
   input  wire                  areset,
   rr_arb_out_fifo_if.slave     bus
);
   localparam int c_PTR_W = $clog2(DEPTH);
   localparam int c_CNT_W = $clog2(DEPTH + 1);

   localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(DEPTH);
   localparam logic [c_CNT_W-1:0] c_CNT_AFULL = c_CNT_W'(AFULL_THR);
   localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
   localparam logic [c_PTR_W-1:0] c_PTR_ONE   = c_PTR_W'(1);

   // Elaboration-time parameter sanity: pointers wrap by overflow, so DEPTH
   // has to be a power of two, and the threshold must be reachable.
   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
      $error("rr_arb_out_fifo: DEPTH must be a power of two >= 2");
   end
   if ((AFULL_THR < 1) || (AFULL_THR > DEPTH)) begin : g_afull_check
      $error("rr_arb_out_fifo: AFULL_THR must lie in 1..DEPTH");
   end

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [c_PTR_W-1:0]    r_wr_ptr;
   logic [c_PTR_W-1:0]    r_rd_ptr;
   logic [c_CNT_W-1:0]    r_count;

   logic                  w_prev_ready;
   logic                  w_next_valid;
   logic                  w_push;
   logic                  w_pop;
   logic [c_CNT_W-1:0]    w_count_nxt;

   // Ready/valid come from the count register only, so there is no
   // combinational path from next_ready_i to prev_ready_o. The price is a
   // one-cycle bubble when a full FIFO is popped.
   assign w_prev_ready = (r_count != c_CNT_FULL);
   assign w_next_valid = (r_count != '0);
   assign w_push       = bus.prev_valid_i & w_prev_ready;
   assign w_pop        = w_next_valid & bus.next_ready_i;

   // Occupancy update: simultaneous push and pop leave the count unchanged.
   always_comb begin
      w_count_nxt = r_count;
      if (w_push && !w_pop) begin
         w_count_nxt = r_count + c_CNT_ONE;
      end else if (w_pop && !w_push) begin
         w_count_nxt = r_count - c_CNT_ONE;
      end
   end

   // Storage array: written on push, deliberately not reset.
   always_ff @(posedge aclk) begin
      if (w_push && !areset) begin
         r_mem[r_wr_ptr] <= bus.prev_data_i;
      end
   end

   // Pointers and count; reset discards all entries and any same-cycle push/pop.
   always_ff @(posedge aclk) begin
      if (areset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
         end
         r_count <= w_count_nxt;
      end
   end

   // Head entry falls through combinationally from the registered array;
   // it stays put until popped because rd_ptr only moves on a pop.
   assign bus.prev_ready_o  = w_prev_ready;
   assign bus.next_valid_o  = w_next_valid;
   assign bus.next_data_o   = r_mem[r_rd_ptr];
   assign bus.count_o       = r_count;
   assign bus.almost_full_o = (r_count >= c_CNT_AFULL);

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_out_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb_out_fifo
//  Description : Self-checking bench for rr_arb_out_fifo (16-bit, depth 4,
//                almost-full threshold 3) against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb_out_fifo;
   localparam int DW    = 16;
   localparam int DEPTH = 4;
   localparam int AFULL = 3;

   logic aclk;
   logic areset;

   rr_arb_out_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

   rr_arb_out_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AFULL_THR(AFULL)) dut (
      .aclk   (aclk),
      .areset (areset),
      .bus    (bus)
   );

   int checks = 0;
   int errors = 0;

   // model state
   logic [DW-1:0] q[$];
   bit            started = 0;
   // words the DUT actually delivered downstream
   logic [DW-1:0] out_log[$];

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Reference model: a plain queue updated from inputs and its own occupancy.
   always @(posedge aclk) begin
      bit push, pop;
      if (areset) begin
         q.delete();
         started = 1;
      end else if (started) begin
         push = bus.prev_valid_i && (q.size() != DEPTH);
         pop  = bus.next_ready_i && (q.size() != 0);
         if (pop)  void'(q.pop_front());
         if (push) q.push_back(bus.prev_data_i);
      end
   end

   // Delivered-word log taken from the DUT handshake.
   always @(posedge aclk) begin
      if (!areset && bus.next_valid_o === 1'b1 && bus.next_ready_i)
         out_log.push_back(bus.next_data_o);
   end

   // Per-cycle comparison of all outputs against the model.
   always @(negedge aclk) begin
      if (started && !areset) begin
         chk("m_next_valid", 32'(bus.next_valid_o), 32'(q.size() != 0));
         chk("m_prev_ready", 32'(bus.prev_ready_o), 32'(q.size() != DEPTH));
         chk("m_count", 32'(bus.count_o), 32'(q.size()));
         chk("m_afull", 32'(bus.almost_full_o), 32'(q.size() >= AFULL));
         if (q.size() != 0)
            chk("m_head_data", 32'(bus.next_data_o), 32'(q[0]));
      end
   end

   // One clock with the given inputs; returns 1 time unit after the edge.
   task automatic cyc(input logic v, input logic [DW-1:0] d, input logic r);
      bus.prev_valid_i = v;
      bus.prev_data_i  = d;
      bus.next_ready_i = r;
      @(posedge aclk);
      #1;
   endtask

   initial begin
      int n;
      logic [DW-1:0] seq;
      areset           = 1'b1;
      bus.prev_valid_i = 1'b0;
      bus.prev_data_i  = '0;
      bus.next_ready_i = 1'b0;
      repeat (2) @(posedge aclk);
      #1;
      areset = 1'b0;

      // 1. reset then idle
      cyc(0, 16'h0, 0);
      chk("rst_next_valid", 32'(bus.next_valid_o), 0);
      chk("rst_prev_ready", 32'(bus.prev_ready_o), 1);
      chk("rst_count", 32'(bus.count_o), 0);
      chk("rst_afull", 32'(bus.almost_full_o), 0);

      // 2. single push, visible the next cycle
      bus.prev_valid_i = 1; bus.prev_data_i = 16'hA001; bus.next_ready_i = 0;
      @(negedge aclk);
      chk("no_flow_through", 32'(bus.next_valid_o), 0);
      @(posedge aclk); #1;
      chk("t2_valid", 32'(bus.next_valid_o), 1);
      chk("t2_data", 32'(bus.next_data_o), 32'h0000A001);
      chk("t2_count", 32'(bus.count_o), 1);
      cyc(0, 16'h0, 1);
      chk("t2_popped", 32'(out_log[out_log.size()-1]), 32'h0000A001);
      chk("t2_count_after", 32'(bus.count_o), 0);

      // 3. fill to full, reject extra push, drain in order
      out_log.delete();
      cyc(1, 16'h0001, 0);
      cyc(1, 16'h0002, 0);
      chk("t3_afull_at2", 32'(bus.almost_full_o), 0);
      cyc(1, 16'h0003, 0);
      chk("t3_afull_at3", 32'(bus.almost_full_o), 1);
      cyc(1, 16'h0004, 0);
      chk("t3_count_full", 32'(bus.count_o), 4);
      chk("t3_ready_full", 32'(bus.prev_ready_o), 0);
      chk("t3_afull_full", 32'(bus.almost_full_o), 1);
      cyc(1, 16'h0005, 0);
      chk("t3_count_reject", 32'(bus.count_o), 4);
      cyc(1, 16'h0005, 1);              // pop while full; push still blocked
      chk("t3_bubble_count", 32'(bus.count_o), 3);
      cyc(0, 16'h0, 1);
      cyc(0, 16'h0, 1);
      cyc(0, 16'h0, 1);
      chk("t3_count_empty", 32'(bus.count_o), 0);
      chk("t3_out_n", 32'(out_log.size()), 4);
      for (int i = 0; i < 4; i++)
         if (i < out_log.size())
            chk("t3_order", 32'(out_log[i]), 32'(i + 1));

      // 4. steady stream of 12 words
      out_log.delete();
      for (int i = 0; i < 12; i++) begin
         cyc(1, 16'h0100 + 16'(i), 1);
         chk("t4_count_hold", 32'(bus.count_o), 1);
      end
      cyc(0, 16'h0, 1);
      chk("t4_out_n", 32'(out_log.size()), 12);
      for (int i = 0; i < 12; i++)
         if (i < out_log.size())
            chk("t4_order", 32'(out_log[i]), 32'h100 + 32'(i));

      // 5. random valid/ready; per-cycle compare covers order and count
      seq = 16'h1000;
      for (int i = 0; i < 1000; i++) begin
         n = $urandom_range(0, 3);
         cyc(n[0], n[0] ? seq : 16'($urandom), n[1]);
         seq = seq + 16'(n[0]);
      end
      repeat (DEPTH + 1) cyc(0, 16'h0, 1);

      // 6. reset mid-operation with push and pop asserted
      cyc(1, 16'h0C01, 0);
      cyc(1, 16'h0C02, 0);
      cyc(1, 16'h0C03, 0);
      chk("t6_count_pre", 32'(bus.count_o), 3);
      areset = 1'b1;
      cyc(1, 16'hDEAD, 1);
      areset = 1'b0;
      chk("t6_count_rst", 32'(bus.count_o), 0);
      chk("t6_valid_rst", 32'(bus.next_valid_o), 0);
      out_log.delete();
      cyc(1, 16'hBEEF, 0);
      cyc(0, 16'h0, 1);
      chk("t6_out_n", 32'(out_log.size()), 1);
      if (out_log.size() != 0)
         chk("t6_first_out", 32'(out_log[0]), 32'h0000BEEF);
      cyc(0, 16'h0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
